signal_playback_ctrl: RTL and testbench
=======================================

# signal_playback_ctrl

Playback sequencer for the 1k-sample signal BRAM reader. It generates the reader's clock-enable at a programmable sample rate and holds the reader in reset while idle, so every run starts at sample 0. It plays a programmed number of full 1024-sample periods, or plays continuously until stopped. It also provides a valid strobe aligned to the reader's output, a sample-index mirror and run status, for the downstream FIR/DAC path and the PS register interface.

## Interface
- `DIV_WIDTH`, 16, width of the rate divider.
- `PER_WIDTH`, 16, width of the period count and counter.
- `clk` in 1: system clock, shared with the reader.
- `rstn` in 1: asynchronous active-low reset.
- `i_start` in 1: start request, sampled only in IDLE.
- `i_stop` in 1: abort request, sampled in IDLE and RUN.
- `i_continuous` in 1: 1 = loop until stopped; latched at start.
- `i_div` in DIV_WIDTH: ce period minus 1 (0 = ce every cycle); latched at start.
- `i_periods` in PER_WIDTH: number of 1024-sample periods in single-shot mode; 0 is treated as 1; latched at start.
- `o_ce` out 1: reader clock-enable.
- `o_reader_rstn` out 1: reader synchronous reset (low = held at index 0).
- `o_valid` out 1: reader output `o14_signal` is a new sample this cycle.
- `o_index` out 10: index of the sample presented with `o_valid`.
- `o_period_cnt` out PER_WIDTH: number of completed periods in the current run.
- `o_busy` out 1: high in RUN and FLUSH.
- `o_done` out 1: one-cycle pulse at the end of a run.
- `o_aborted` out 1: sticky; set if the last run ended by `i_stop`; cleared at start.

## Operation
- States:
  - IDLE: reader held in reset, no ce.
  - RUN: prescaler runs and issues ce.
  - FLUSH: one cycle that delivers the final valid.
- IDLE→RUN on `i_start` && !`i_stop`.
  - Latch `i_div`, `i_continuous` and `i_periods` (0→1).
  - Clear the prescaler, the sample index, `o_period_cnt` and `o_aborted`.
- Start and stop in the same IDLE cycle: stop wins, state stays IDLE.
- `i_start` outside IDLE is ignored. Input changes during a run are ignored.
- Prescaler in RUN counts 0..div and wraps.
  - `o_ce` = (state==RUN) && (prescaler==div_latched).
  - `o_ce` is decoded from registers only, with no input-to-output path.
- On each ce, the sample index increments modulo 1024.
- A ce with index==1023 completes a period and increments `o_period_cnt`.
  - `o_period_cnt` saturates at all-ones in continuous mode.
- Single-shot mode: the ce that completes period P (the latched count) causes RUN→FLUSH. Exactly 1024·P ces per run.
- `i_stop` in RUN causes RUN→FLUSH.
  - A ce decoded in that same cycle still occurs.
  - `o_aborted` is set.
- FLUSH→IDLE unconditionally.
  - `o_done`=1 during the FLUSH cycle.
  - `o_valid` in FLUSH equals the ce of the previous cycle.
- `o_valid` is `o_ce` delayed by one cycle. `o_index` is the index value used by that ce, delayed by one cycle.
- `o_reader_rstn` = 0 in IDLE, 1 in RUN and FLUSH (registered).

## Timing
- All outputs reset to 0 asynchronously, including `o_reader_rstn`=0 and state IDLE.
- Start sampled at edge k:
  - From edge k+1: RUN, `o_busy`=1, `o_reader_rstn`=1.
  - First `o_ce` is in cycle k+1+div.
  - First `o_valid` is in cycle k+2+div, with `o_index`=0.
- ce spacing: exactly div+1 cycles, including across period wraps.
- Single-shot run length from the start edge: 1024·P·(div+1) cycles of RUN, then 1 FLUSH cycle, then IDLE.
- Stop sampled at edge s in RUN: FLUSH in cycle s+1, IDLE in cycle s+2, and no ce after cycle s.
- Async reset mid-run:
  - Immediate IDLE; `o_ce` and `o_valid` drop, and `o_reader_rstn` goes low at once.
  - No `o_done` is generated.

## Structure
- Package `signal_playback_pkg`:
  - state enum {IDLE, RUN, FLUSH};
  - `SAMPLES_PER_PERIOD`=1024;
  - `INDEX_WIDTH`=10.
- Sub-module `ce_prescaler`:
  - async-reset counter with `clr`, `en`, `div` inputs;
  - `tick` output (count==div).
- The FSM, index/period counters and output alignment live in the top.

## Test plan
- div=0, P=1, start at edge 0:
  - `o_ce` high in cycles 1..1024;
  - `o_valid` in cycles 2..1025 with `o_index` 0..1023;
  - `o_done` in cycle 1025, `o_period_cnt`=1, `o_aborted`=0.
- div=3, P=2:
  - ce every 4 cycles, 2048 ces in total;
  - `o_index` wraps 1023→0;
  - `o_period_cnt` goes 1 then 2;
  - `o_done` 8193 cycles after start.
- `i_periods`=0, div=0: behaves as P=1, exactly 1024 ces.
- Continuous mode, div=1, `i_stop` pulsed after 3000 cycles:
  - FLUSH and `o_done` on the next cycle, `o_aborted`=1;
  - `o_period_cnt`=1;
  - no ce after the stop cycle.
- `i_start` and `i_stop` together in IDLE: no state change, `o_reader_rstn` stays 0. `i_start` while in RUN: ignored.
- `rstn` asserted mid-run:
  - all outputs go to 0 immediately, no `o_done`;
  - a new start afterwards gives `o_index`=0 on the first valid.

Source files
------------

// File: rtl/signal_playback_pkg.sv
// Shared types and constants for the signal BRAM playback sequencer.
package signal_playback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int SAMPLES_PER_PERIOD = 1024;
  localparam int INDEX_WIDTH        = 10;

endpackage

// File: rtl/ce_prescaler.sv
// Rate divider: counts 0..div and wraps, tick marks the terminal count.
module ce_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == div) ? '0 : count + 1'b1;
    end
  end

  // Decoded from registers only, so ce has no path from any input.
  assign tick = (count == div);

endmodule

// File: rtl/signal_playback_ctrl.sv
// Playback sequencer: paces the BRAM reader with a programmable ce, counts
// samples and periods, and aligns a valid/index strobe with the reader output.
module signal_playback_ctrl
  import signal_playback_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int PER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_continuous,
  input  logic [DIV_WIDTH-1:0]   i_div,
  input  logic [PER_WIDTH-1:0]   i_periods,
  output logic                   o_ce,
  output logic                   o_reader_rstn,
  output logic                   o_valid,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [PER_WIDTH-1:0]   o_period_cnt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted
);

  state_t                 state_q, state_d;
  logic                   start_run;
  logic                   tick;
  logic                   ce;
  logic                   last_sample;
  logic                   last_period;
  logic [DIV_WIDTH-1:0]   div_q;
  logic                   cont_q;
  logic [PER_WIDTH-1:0]   periods_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [PER_WIDTH-1:0]   period_cnt_q;
  logic                   aborted_q;
  logic                   reader_rstn_q;
  logic                   vld_p1;
  logic [INDEX_WIDTH-1:0] index_p1;

  ce_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_q != RUN),
    .en   (state_q == RUN),
    .div  (div_q),
    .tick (tick)
  );

  assign ce          = (state_q == RUN) && tick;
  assign last_sample = (idx_q == INDEX_WIDTH'(SAMPLES_PER_PERIOD - 1));
  assign last_period = (period_cnt_q == periods_q - PER_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (i_stop || (ce && last_sample && !cont_q && last_period)) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: control state, run configuration and sample/period counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      div_q         <= '0;
      cont_q        <= 1'b0;
      periods_q     <= '0;
      idx_q         <= '0;
      period_cnt_q  <= '0;
      aborted_q     <= 1'b0;
      reader_rstn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reader_rstn_q <= (state_d != IDLE);
      if (start_run) begin
        div_q        <= i_div;
        cont_q       <= i_continuous;
        periods_q    <= (i_periods == '0) ? PER_WIDTH'(1) : i_periods;
        idx_q        <= '0;
        period_cnt_q <= '0;
        aborted_q    <= 1'b0;
      end else begin
        if (ce) begin
          idx_q <= idx_q + 1'b1;
          // Saturation only matters in continuous mode; single-shot stops first.
          if (last_sample && !(cont_q && (&period_cnt_q))) begin
            period_cnt_q <= period_cnt_q + 1'b1;
          end
        end
        if ((state_q == RUN) && i_stop) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  // Stage p1: valid/index aligned with the reader's registered output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      index_p1 <= '0;
    end else begin
      vld_p1 <= ce;
      if (ce) begin
        index_p1 <= idx_q;
      end
    end
  end

  assign o_ce          = ce;
  assign o_reader_rstn = reader_rstn_q;
  assign o_valid       = vld_p1;
  assign o_index       = index_p1;
  assign o_period_cnt  = period_cnt_q;
  assign o_busy        = (state_q == RUN) || (state_q == FLUSH);
  assign o_done        = (state_q == FLUSH);
  assign o_aborted     = aborted_q;

endmodule

// File: tb/tb_signal_playback_ctrl.sv
// Directed bench for signal_playback_ctrl: single-shot, continuous/stop, and reset scenarios.
module tb_signal_playback_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start, i_stop, i_continuous;
  logic [15:0] i_div, i_periods;
  logic        o_ce, o_reader_rstn, o_valid, o_busy, o_done, o_aborted;
  logic [9:0]  o_index;
  logic [15:0] o_period_cnt;

  int total = 0;
  int bad   = 0;

  // run statistics gathered by monitor()
  int ce_count, first_ce, last_ce, spacing_bad;
  int valid_count, first_valid, idx_bad;
  int done_cycle, pcnt_done, aborted_done, busy_bad;
  int pcnt_changes, pcnt_first;
  logic [9:0]  exp_idx;
  logic [15:0] pcnt_last;

  signal_playback_ctrl #(.DIV_WIDTH(16), .PER_WIDTH(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_continuous  (i_continuous),
    .i_div         (i_div),
    .i_periods     (i_periods),
    .o_ce          (o_ce),
    .o_reader_rstn (o_reader_rstn),
    .o_valid       (o_valid),
    .o_index       (o_index),
    .o_period_cnt  (o_period_cnt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_aborted     (o_aborted)
  );

  always #5 clk = ~clk;

  task automatic start_run(input int div, input int periods, input logic cont);
    @(negedge clk);
    i_div        = 16'(div);
    i_periods    = 16'(periods);
    i_continuous = cont;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_div        = 16'hBEEF;
    i_periods    = 16'h0007;
    i_continuous = ~cont;
  endtask

  // Cycle c=1 is the cycle right after the edge that sampled the start.
  task automatic monitor(input int max_cyc, input int div, input int stop_at, input int restart_at);
    int last;
    last = 0;
    ce_count = 0; first_ce = -1; last_ce = -1; spacing_bad = 0;
    valid_count = 0; first_valid = -1; idx_bad = 0;
    done_cycle = -1; pcnt_done = -1; aborted_done = -1; busy_bad = 0;
    pcnt_changes = 0; pcnt_first = -1; pcnt_last = 16'd0; exp_idx = 10'd0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (o_ce) begin
        if (ce_count == 0) first_ce = c;
        else if (c - last != div + 1) spacing_bad++;
        last = c; last_ce = c; ce_count++;
      end
      if (o_valid) begin
        if (valid_count == 0) first_valid = c;
        if (o_index !== exp_idx) idx_bad++;
        exp_idx = exp_idx + 10'd1;
        valid_count++;
      end
      if (o_period_cnt !== pcnt_last) begin
        if (pcnt_changes == 0) pcnt_first = int'(o_period_cnt);
        pcnt_changes++;
        pcnt_last = o_period_cnt;
      end
      if (o_busy !== 1'b1 || o_reader_rstn !== 1'b1) busy_bad++;
      if (o_done === 1'b1) begin
        done_cycle = c; pcnt_done = int'(o_period_cnt); aborted_done = int'(o_aborted);
        break;
      end
      i_stop  = (c == stop_at);
      i_start = (c == restart_at);
    end
    i_stop  = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0;
    i_div = 16'd0; i_periods = 16'd0;
    #12;
    total++;
    if ({o_ce, o_reader_rstn, o_valid, o_index, o_period_cnt, o_busy, o_done, o_aborted} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ce=%b rrst=%b vld=%b idx=%0d pc=%0d busy=%b done=%b ab=%b, want all 0",
               o_ce, o_reader_rstn, o_valid, o_index, o_period_cnt, o_busy, o_done, o_aborted);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_div0;
    start_run(0, 1, 1'b0);
    monitor(1100, 0, 0, 0);
    total++; if (first_ce !== 1)     begin bad++; $display("FAIL d0_first_ce: got %0d want 1", first_ce); end
    total++; if (last_ce !== 1024)   begin bad++; $display("FAIL d0_last_ce: got %0d want 1024", last_ce); end
    total++; if (ce_count !== 1024)  begin bad++; $display("FAIL d0_ce_count: got %0d want 1024", ce_count); end
    total++; if (first_valid !== 2)  begin bad++; $display("FAIL d0_first_valid: got %0d want 2", first_valid); end
    total++; if (valid_count !== 1024 || idx_bad !== 0)
      begin bad++; $display("FAIL d0_valid_index: got count=%0d idx_errs=%0d want 1024/0", valid_count, idx_bad); end
    total++; if (done_cycle !== 1025) begin bad++; $display("FAIL d0_done_cycle: got %0d want 1025", done_cycle); end
    total++; if (pcnt_done !== 1 || aborted_done !== 0)
      begin bad++; $display("FAIL d0_status: got pcnt=%0d aborted=%0d want 1/0", pcnt_done, aborted_done); end
    total++; if (busy_bad !== 0) begin bad++; $display("FAIL d0_busy_rrst: got %0d bad cycles want 0", busy_bad); end
    @(negedge clk);
    total++; if ({o_busy, o_reader_rstn, o_valid, o_done} !== 4'b0000)
      begin bad++; $display("FAIL d0_idle_after: got busy/rrst/vld/done=%b want 0000", {o_busy, o_reader_rstn, o_valid, o_done}); end
  endtask

  task automatic test_div3_two_periods;
    start_run(3, 2, 1'b0);
    monitor(8300, 3, 0, 0);
    total++; if (ce_count !== 2048 || spacing_bad !== 0 || first_ce !== 4)
      begin bad++; $display("FAIL d3_ce: got count=%0d spacing_errs=%0d first=%0d want 2048/0/4", ce_count, spacing_bad, first_ce); end
    total++; if (valid_count !== 2048 || idx_bad !== 0)
      begin bad++; $display("FAIL d3_index_wrap: got count=%0d idx_errs=%0d want 2048/0", valid_count, idx_bad); end
    total++; if (pcnt_changes !== 2 || pcnt_first !== 1 || pcnt_done !== 2)
      begin bad++; $display("FAIL d3_period_cnt: got changes=%0d first=%0d final=%0d want 2/1/2", pcnt_changes, pcnt_first, pcnt_done); end
    total++; if (done_cycle !== 8193) begin bad++; $display("FAIL d3_done_cycle: got %0d want 8193", done_cycle); end
  endtask

  task automatic test_periods_zero;
    start_run(0, 0, 1'b0);
    monitor(1100, 0, 0, 0);
    total++; if (ce_count !== 1024 || done_cycle !== 1025)
      begin bad++; $display("FAIL p0_as_one: got ces=%0d done=%0d want 1024/1025", ce_count, done_cycle); end
  endtask

  task automatic test_continuous_stop;
    start_run(1, 1, 1'b1);
    monitor(3100, 1, 3000, 0);
    total++; if (done_cycle !== 3001) begin bad++; $display("FAIL cs_done_cycle: got %0d want 3001", done_cycle); end
    total++; if (aborted_done !== 1 || pcnt_done !== 1)
      begin bad++; $display("FAIL cs_status: got aborted=%0d pcnt=%0d want 1/1", aborted_done, pcnt_done); end
    total++; if (last_ce !== 3000 || ce_count !== 1500 || spacing_bad !== 0)
      begin bad++; $display("FAIL cs_ce: got last=%0d count=%0d spacing_errs=%0d want 3000/1500/0", last_ce, ce_count, spacing_bad); end
    @(negedge clk);
    total++; if ({o_ce, o_busy, o_aborted} !== 3'b001)
      begin bad++; $display("FAIL cs_after: got ce/busy/aborted=%b want 001", {o_ce, o_busy, o_aborted}); end
  endtask

  task automatic test_start_stop_idle;
    int ce_seen;
    ce_seen = 0;
    @(negedge clk);
    i_div = 16'd0; i_periods = 16'd1; i_start = 1'b1; i_stop = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_ce !== 1'b0 || o_busy !== 1'b0 || o_reader_rstn !== 1'b0) ce_seen++;
    end
    total++; if (ce_seen !== 0) begin bad++; $display("FAIL start_stop_idle: got %0d active cycles want 0", ce_seen); end
  endtask

  task automatic test_start_in_run;
    start_run(2, 1, 1'b0);
    monitor(3200, 2, 0, 500);
    total++; if (ce_count !== 1024 || done_cycle !== 3073 || spacing_bad !== 0)
      begin bad++; $display("FAIL restart_ignored: got ces=%0d done=%0d spacing_errs=%0d want 1024/3073/0", ce_count, done_cycle, spacing_bad); end
    total++; if (aborted_done !== 0) begin bad++; $display("FAIL aborted_cleared: got %0d want 0", aborted_done); end
  endtask

  task automatic test_reset_mid_run;
    int done_seen;
    done_seen = 0;
    start_run(0, 1, 1'b0);
    monitor(100, 0, 0, 0);
    total++; if (done_cycle !== -1 || ce_count !== 100)
      begin bad++; $display("FAIL mr_prerun: got done=%0d ces=%0d want -1/100", done_cycle, ce_count); end
    #2 rstn = 1'b0;
    #1;
    total++; if ({o_ce, o_reader_rstn, o_valid, o_index, o_period_cnt, o_busy, o_done, o_aborted} !== '0)
      begin bad++; $display("FAIL mr_async_clear: got ce=%b rrst=%b vld=%b idx=%0d busy=%b done=%b want all 0",
                            o_ce, o_reader_rstn, o_valid, o_index, o_busy, o_done); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done !== 1'b0) done_seen++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (o_done !== 1'b0) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL mr_no_done: got %0d done cycles want 0", done_seen); end
    start_run(1, 1, 1'b0);
    monitor(2100, 1, 0, 0);
    total++; if (first_valid !== 3 || idx_bad !== 0 || done_cycle !== 2049)
      begin bad++; $display("FAIL mr_restart: got first_valid=%0d idx_errs=%0d done=%0d want 3/0/2049", first_valid, idx_bad, done_cycle); end
  endtask

  initial begin
    test_reset();
    test_single_div0();
    test_div3_two_periods();
    test_periods_zero();
    test_continuous_stop();
    test_start_stop_idle();
    test_start_in_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
